debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel switch debouncer: synchronises NUM_CH asynchronous switch inputs, filters each channel independently against a programmable stable-time, and emits the debounced level plus one-cycle rise/fall strobes per channel. It sits between the board's push-buttons/DIP switches and the user logic, so downstream state machines consume clean single-cycle events instead of re-detecting edges. An optional long-press detector per channel is compiled in by macro.

## Interface
- NUM_CH, 4, number of independent switch channels (≥1)
- DEBOUNCE_COUNT, 250000, consecutive clock cycles a new synchronised level must hold before it is accepted (≥1)
- HOLD_COUNT, 25000000, cycles o_Switch must stay high, measured from the o_Rise cycle, before o_Hold fires (≥1; used only with DEBOUNCE_HOLD_EN)
- Localparams: CNT_W = $clog2(DEBOUNCE_COUNT+1), HOLD_W = $clog2(HOLD_COUNT+1)

- i_Clk  input  1  system clock; all state on rising edge
- i_Rst_L  input  1  asynchronous, active-low reset
- i_Switch  input  NUM_CH  raw switch levels, asynchronous to i_Clk
- o_Switch  output  NUM_CH  debounced level per channel
- o_Rise  output  NUM_CH  one-cycle pulse when o_Switch goes 0→1
- o_Fall  output  NUM_CH  one-cycle pulse when o_Switch goes 1→0
- o_Hold  output  NUM_CH  one-cycle pulse on long press (constant 0 without DEBOUNCE_HOLD_EN)

## Operation
- Per channel: 2-flop synchroniser (sync1 → sync2), CNT_W-bit stability counter, registered state bit driving o_Switch.
- Each edge, per channel:
  - sync2 == state: counter ← 0.
  - sync2 != state and counter < DEBOUNCE_COUNT-1: counter ← counter+1.
  - sync2 != state and counter == DEBOUNCE_COUNT-1: state ← sync2, counter ← 0, o_Rise or o_Fall ← 1 per direction.
- Any single-cycle return of sync2 to state clears the counter; a glitch never propagates and a new attempt restarts from 0.
- o_Rise/o_Fall registered; high exactly one cycle, coincident with the first cycle of the new o_Switch level; never both high on one channel.
- Counter never exceeds DEBOUNCE_COUNT-1; no wrap.
- Channels fully independent; simultaneous transitions on several channels produce simultaneous strobes.

## Timing
- Reset (i_Rst_L low, asynchronous): sync flops, counters, state, o_Switch, o_Rise, o_Fall, o_Hold and hold counters all 0 immediately.
- Reset release with switches already high: no strobe on the release edge; channel debounces normally, giving o_Rise after the full latency.
- Reset asserted mid-count or mid-pulse: everything cleared in the same instant; no pulse completes.
- Latency: take the first edge at which sync1 captures the new stable i_Switch level as edge 0; o_Switch and its strobe change after edge DEBOUNCE_COUNT+1 (DEBOUNCE_COUNT=4 → after edge 5).
- Minimum spacing between consecutive strobes on one channel: DEBOUNCE_COUNT cycles.

## Configuration
- DEBOUNCE_HOLD_EN defined: per channel HOLD_W-bit hold counter; cleared while o_Switch==0 and on the o_Rise cycle; increments each cycle o_Switch==1 up to HOLD_COUNT, then saturates. o_Hold pulses one cycle on the edge the counter reaches HOLD_COUNT, i.e. HOLD_COUNT cycles after o_Rise. Single pulse per press; re-armed only by o_Fall. Release before HOLD_COUNT → no o_Hold.
- DEBOUNCE_HOLD_EN undefined: no hold logic synthesised; o_Hold tied to 0; port list unchanged.

## Test plan
- Reset: drive i_Switch=4'b1111 while i_Rst_L=0 → all outputs 0; release → after edge DEBOUNCE_COUNT+1 (DEBOUNCE_COUNT=4), o_Switch=4'b1111, o_Rise=4'b1111 for exactly one cycle.
- Bounce: DEBOUNCE_COUNT=4, ch0 toggles 1,0,1,0 at 1-cycle intervals then holds 1 → no strobe during toggling; single o_Rise[0] 5 edges after the final stable sample; o_Fall[0] never asserted.
- Release: ch2 held high then driven 0 for 3 cycles and back to 1 → no change; then 0 held → o_Fall[2] once, o_Switch[2]=0; other channels unaffected.
- Simultaneous: ch1 rises while ch3 falls on the same cycle → o_Rise=4'b0010 and o_Fall=4'b1000 on the same cycle.
- Async reset mid-count: assert i_Rst_L low for half a clock while ch0's counter is at 2 → outputs 0 immediately; after release ch0 needs a full DEBOUNCE_COUNT again.
- DEBOUNCE_HOLD_EN, HOLD_COUNT=10: press held → o_Hold[0] exactly once, 10 cycles after o_Rise[0]; press released after 6 cycles → no o_Hold; without the macro o_Hold stays 0 throughout.

Source files
------------

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-flop sync, per-channel stability counter, level plus rise/fall strobes.
// Optional long-press detector per channel compiled in with `define DEBOUNCE_HOLD_EN.
module debounce_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_COUNT = 250000,
    parameter int HOLD_COUNT     = 25000000
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

`ifdef DEBOUNCE_HOLD_EN
    localparam int HOLD_W = $clog2(HOLD_COUNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_COUNT - 1);
`endif

    if (NUM_CH < 1 || DEBOUNCE_COUNT < 1 || HOLD_COUNT < 1) begin : g_bad_params
        $error("debounce_bank: NUM_CH, DEBOUNCE_COUNT and HOLD_COUNT must all be >= 1");
    end

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             state;
        logic             rise;
        logic             fall;
        logic             accept;

        // The new level is taken on the edge where it has been seen DEBOUNCE_COUNT times in a row.
        assign accept = (sync2[ch] != state) && (cnt == CNT_LAST);

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                cnt   <= '0;
                state <= 1'b0;
                rise  <= 1'b0;
                fall  <= 1'b0;
            end else begin
                rise <= 1'b0;
                fall <= 1'b0;
                if (sync2[ch] == state) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt   <= '0;
                    state <= sync2[ch];
                    rise  <= sync2[ch];
                    fall  <= ~sync2[ch];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign o_Switch[ch] = state;
        assign o_Rise[ch]   = rise;
        assign o_Fall[ch]   = fall;

`ifdef DEBOUNCE_HOLD_EN
        logic [HOLD_W-1:0] hold_cnt;
        logic              hold;

        // Counter sits at 0 through the o_Rise cycle and saturates, so each press gives one pulse.
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                hold_cnt <= '0;
                hold     <= 1'b0;
            end else begin
                hold <= 1'b0;
                if (!state || accept) begin
                    hold_cnt <= '0;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_PRE) begin
                        hold <= 1'b1;
                    end
                end
            end
        end

        assign o_Hold[ch] = hold;
`else
        assign o_Hold[ch] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank with NUM_CH=4, DEBOUNCE_COUNT=4, HOLD_COUNT=10: vector table plus
// reset/long-press sequences; strobe events are scheduled in exp_q and matched by a monitor.
module tb_debounce_bank;

    localparam int NCH  = 4;
    localparam int DC   = 4;
    localparam int HOLD = 10;
`ifdef DEBOUNCE_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic           i_Clk = 1'b0;
    logic           i_Rst_L = 1'b0;
    logic [NCH-1:0] i_Switch = '0;
    logic [NCH-1:0] o_Switch;
    logic [NCH-1:0] o_Rise;
    logic [NCH-1:0] o_Fall;
    logic [NCH-1:0] o_Hold;

    debounce_bank #(
        .NUM_CH        (NCH),
        .DEBOUNCE_COUNT(DC),
        .HOLD_COUNT    (HOLD)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Switch(i_Switch),
        .o_Switch(o_Switch),
        .o_Rise  (o_Rise),
        .o_Fall  (o_Fall),
        .o_Hold  (o_Hold)
    );

    // clock / cycle counter
    always #5 i_Clk = ~i_Clk;

    int cyc = 0;
    always @(posedge i_Clk) cyc <= cyc + 1;

    // scoreboard: {due cycle, o_Switch at event, o_Rise, o_Fall}
    localparam int W = 32 + 3 * NCH;
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int hold_due[NCH] = '{default: -1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected strobe relative to the negedge where the new level is driven.
    task automatic expect_event(input logic [NCH-1:0] sw, input logic [NCH-1:0] r,
                                input logic [NCH-1:0] f);
        logic [31:0] due;
        due = 32'(cyc + DC + 2);
        exp_q.push_back({due, sw, r, f});
    endtask

    always @(negedge i_Rst_L) begin
        for (int k = 0; k < NCH; k++) hold_due[k] = -1;
    end

    // monitor
    always @(negedge i_Clk) begin
        logic [W-1:0]   e;
        logic [NCH-1:0] exp_hold;
        if (i_Rst_L) begin
            while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe: expected at cycle %0d, still absent at cycle %0d",
                         exp_q[0][W-1 -: 32], cyc);
                void'(exp_q.pop_front());
            end
            if ((o_Rise | o_Fall) != '0) begin
                if (exp_q.size() == 0 || int'(exp_q[0][W-1 -: 32]) != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe at cycle %0d: rise %b fall %b, required none",
                             cyc, o_Rise, o_Fall);
                end else begin
                    e = exp_q.pop_front();
                    check("event_switch", 32'(o_Switch), 32'(e[3*NCH-1 -: NCH]));
                    check("event_rise", 32'(o_Rise), 32'(e[2*NCH-1 -: NCH]));
                    check("event_fall", 32'(o_Fall), 32'(e[NCH-1:0]));
                    for (int k = 0; k < NCH; k++) begin
                        if (e[NCH + k]) hold_due[k] = cyc + HOLD;
                        if (e[k]) hold_due[k] = -1;
                    end
                end
            end
            for (int k = 0; k < NCH; k++) exp_hold[k] = HOLD_EN && (hold_due[k] == cyc);
            if (o_Hold != '0 || exp_hold != '0) check("hold_pulse", 32'(o_Hold), 32'(exp_hold));
        end
    end

    // vector table
    typedef struct {
        logic [NCH-1:0] sw;
        int             n;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        logic [NCH-1:0] ev_sw;
        logic [NCH-1:0] end_sw;
    } vec_t;

    vec_t vecs[16];

    task automatic run_vec(input vec_t v, input int idx);
        i_Switch = v.sw;
        if ((v.rise | v.fall) != '0) expect_event(v.ev_sw, v.rise, v.fall);
        repeat (v.n) @(negedge i_Clk);
        check($sformatf("vec%0d_level", idx), 32'(o_Switch), 32'(v.end_sw));
    endtask

    initial begin
        //          sw       n   rise     fall     ev_sw    end_sw
        vecs[0]  = '{4'b1011,  3, 4'b0000, 4'b0000, 4'b0000, 4'b1111}; // ch2 low 3 cycles: ignored
        vecs[1]  = '{4'b1111,  8, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        vecs[2]  = '{4'b1011, 10, 4'b0000, 4'b0100, 4'b1011, 4'b1011}; // ch2 release
        vecs[3]  = '{4'b1001, 10, 4'b0000, 4'b0010, 4'b1001, 4'b1001};
        vecs[4]  = '{4'b0011, 10, 4'b0010, 4'b1000, 4'b0011, 4'b0011}; // ch1 rise + ch3 fall
        vecs[5]  = '{4'b0010,  4, 4'b0000, 4'b0001, 4'b0010, 4'b0011}; // low exactly DC cycles
        vecs[6]  = '{4'b0011, 10, 4'b0001, 4'b0000, 4'b0011, 4'b0011}; // strobes DC apart
        vecs[7]  = '{4'b0000, 10, 4'b0000, 4'b0011, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000}; // bounce 1,0,1,0
        vecs[9]  = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0001,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[11] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vecs[12] = '{4'b0001, 10, 4'b0001, 4'b0000, 4'b0001, 4'b0001};
        vecs[13] = '{4'b0011, 14, 4'b0001, 4'b0000, 4'b0011, 4'b0011}; // long press ch0/ch1
        vecs[14] = '{4'b0111,  6, 4'b0100, 4'b0000, 4'b0111, 4'b0111};
        vecs[15] = '{4'b0011, 14, 4'b0000, 4'b0100, 4'b0011, 4'b0011}; // ch2 short press

        // reset with switches already high
        i_Rst_L  = 1'b0;
        i_Switch = 4'b1111;
        repeat (3) @(negedge i_Clk);
        check("reset_outputs", 32'({o_Switch, o_Rise, o_Fall, o_Hold}), 32'h0);
        i_Rst_L = 1'b1;
        expect_event(4'b1111, 4'b1111, 4'b0000);
        repeat (8) @(negedge i_Clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // async reset while ch0 (falling) and ch1 (rising) counters sit at 2
        i_Switch = 4'b0010;
        repeat (4) @(negedge i_Clk);
        check("pre_reset_level", 32'(o_Switch), 32'h1);
        #2 i_Rst_L = 1'b0;
        #1 check("async_reset", 32'({o_Switch, o_Rise, o_Fall, o_Hold}), 32'h0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        expect_event(4'b0010, 4'b0010, 4'b0000);
        repeat (8) @(negedge i_Clk);

        for (int i = 13; i < 16; i++) run_vec(vecs[i], i);

        repeat (20) @(negedge i_Clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
